// File: rtl/dtb_pkg.sv
// Shared debug trace buffer types: trigger configuration, trigger status,
// default values and the write-controller FSM state encoding.
package dtb_pkg;

    localparam int TRB_DEPTH  = 32;
    localparam int TRB_WIDTH  = 32;
    localparam int TRB_ADDR_W = $clog2(TRB_DEPTH);
    localparam int TRB_POS_W  = $clog2(TRB_WIDTH);

    typedef struct packed {
        logic       trg_mode;        // 0: single event, 1: multiple events
        logic [3:0] trg_num_traces;  // extra events captured in mode 1
        logic [1:0] trg_delay;       // post-trigger length in quarters of DEPTH
    } config_t;

    typedef struct packed {
        logic                  trg_event;
        logic [TRB_POS_W-1:0]  event_pos;
        logic [TRB_ADDR_W-1:0] event_addr;
    } status_t;

    localparam config_t CONFIG_DEFAULT = '{trg_mode: 1'b0, trg_num_traces: 4'd0, trg_delay: 2'd3};
    localparam status_t STATUS_DEFAULT = '{trg_event: 1'b0, event_pos: '0, event_addr: '0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trb_wr_state_t;

endpackage

// File: rtl/trb_prio_enc.sv
// Lowest-set-bit priority encoder: index of the least significant 1 in vec_i.
module trb_prio_enc #(
    parameter int WIDTH = 32,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx_o   = '0;
        valid_o = |vec_i;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IW'(i);
        end
    end

endmodule

// File: rtl/trb_write_ctrl.sv
// Trace buffer write controller: streams valid trace words into a BRAM ring,
// detects a trigger, captures a programmable number of post-trigger words and
// optionally re-arms for further events. Define DTB_EVENT_COUNTER_EN to add a
// saturating trigger event counter output evt_cnt_o.
module trb_write_ctrl
    import dtb_pkg::*;
#(
    parameter int DEPTH = TRB_DEPTH,
    parameter int WIDTH = TRB_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  config_t          conf_i,
    input  logic             conf_valid_i,
    input  logic             arm_i,
    input  logic             stop_i,
    input  logic             data_valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] trigger_i,
    output logic             we_o,
    output logic [AW-1:0]    waddr_o,
    output logic [WIDTH-1:0] wdata_o,
    output status_t          status_o,
`ifdef DTB_EVENT_COUNTER_EN
    output logic [7:0]       evt_cnt_o,
`endif
    output logic             busy_o,
    output logic             done_o
);

    localparam int IW = $clog2(WIDTH);

    trb_wr_state_t    state_q, state_d;
    config_t          conf_q, conf_d;
    status_t          status_q, status_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW-1:0]    post_q, post_d;
    logic [4:0]       evts_q, evts_d;
    logic             we_q, we_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
`ifdef DTB_EVENT_COUNTER_EN
    logic [7:0]       evt_cnt_q, evt_cnt_d;
`endif

    logic          accept, evt_end, trg_vld;
    logic [IW-1:0] trg_idx;
    logic [AW-1:0] p_words;

    trb_prio_enc #(.WIDTH(WIDTH)) u_prio_enc (
        .vec_i   (trigger_i),
        .idx_o   (trg_idx),
        .valid_o (trg_vld)
    );

    // Post-trigger length is a whole number of quarter-buffers, always < DEPTH.
    assign p_words = AW'(conf_q.trg_delay) * AW'(DEPTH / 4);

    // Next-state logic: writes, trigger capture, event sequencing and stop.
    always_comb begin
        state_d  = state_q;
        conf_d   = conf_q;
        status_d = status_q;
        ptr_d    = ptr_q;
        post_d   = post_q;
        evts_d   = evts_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        evt_end  = 1'b0;
`ifdef DTB_EVENT_COUNTER_EN
        evt_cnt_d = evt_cnt_q;
`endif
        accept = data_valid_i && (state_q == ST_ARMED || state_q == ST_POST);
        // An accepted word is always written, even on the cycle stop_i aborts.
        if (accept) begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = data_i;
            ptr_d   = ptr_q + 1'b1;
        end
        if (stop_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (conf_valid_i) conf_d = conf_i;
                    if (arm_i) begin
                        ptr_d    = '0;
                        status_d = STATUS_DEFAULT;
                        evts_d   = '0;
                        state_d  = ST_ARMED;
`ifdef DTB_EVENT_COUNTER_EN
                        evt_cnt_d = '0;
`endif
                    end
                end
                ST_ARMED: begin
                    if (accept && trg_vld) begin
                        status_d.trg_event  = 1'b1;
                        status_d.event_pos  = TRB_POS_W'(trg_idx);
                        status_d.event_addr = TRB_ADDR_W'(ptr_q);
`ifdef DTB_EVENT_COUNTER_EN
                        if (evt_cnt_q != 8'hff) evt_cnt_d = evt_cnt_q + 8'd1;
`endif
                        if (p_words == '0) begin
                            evt_end = 1'b1;
                        end else begin
                            state_d = ST_POST;
                            post_d  = p_words;
                        end
                    end
                end
                ST_POST: begin
                    if (accept) begin
                        post_d = post_q - 1'b1;
                        if (post_q == AW'(1)) evt_end = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // Mode 1 keeps re-arming until trg_num_traces+1 events are captured.
            if (evt_end) begin
                evts_d  = evts_q + 5'd1;
                state_d = (conf_q.trg_mode && (evts_q < {1'b0, conf_q.trg_num_traces}))
                          ? ST_ARMED : ST_DONE;
            end
        end
    end

    // State and output registers; reset aborts any capture at once.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            conf_q   <= CONFIG_DEFAULT;
            status_q <= STATUS_DEFAULT;
            ptr_q    <= '0;
            post_q   <= '0;
            evts_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
`ifdef DTB_EVENT_COUNTER_EN
            evt_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            conf_q   <= conf_d;
            status_q <= status_d;
            ptr_q    <= ptr_d;
            post_q   <= post_d;
            evts_q   <= evts_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
`ifdef DTB_EVENT_COUNTER_EN
            evt_cnt_q <= evt_cnt_d;
`endif
        end
    end

    assign we_o     = we_q;
    assign waddr_o  = waddr_q;
    assign wdata_o  = wdata_q;
    assign status_o = status_q;
    assign busy_o   = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign done_o   = (state_q == ST_DONE);
`ifdef DTB_EVENT_COUNTER_EN
    assign evt_cnt_o = evt_cnt_q;
`endif

endmodule

// File: doc/trb_write_ctrl.md
TRB_WRITE_CTRL -- requirements
Module: trb_write_ctrl

Interface
REQ-001 Parameter: DEPTH, default DTB_PKG::TRB_DEPTH (32), number of trace-buffer words; SHALL be a power of two >= 4.
REQ-002 Parameter: WIDTH, default DTB_PKG::TRB_WIDTH (32), trace word width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk  in  1  sole clock.
- rst_ni  in  1  asynchronous active-low reset.
- conf_i  in  config_t  trigger configuration.
- conf_valid_i  in  1  load conf_i.
- arm_i  in  1  start a capture.
- stop_i  in  1  abort a capture.
- data_valid_i  in  1  data_i/trigger_i valid this cycle.
- data_i  in  WIDTH  trace word.
- trigger_i  in  WIDTH  per-bit trigger flags.
- we_o  out  1  BRAM write enable.
- waddr_o  out  $clog2(DEPTH)  BRAM write address.
- wdata_o  out  WIDTH  BRAM write data.
- status_o  out  status_t  trigger status.
- busy_o  out  1  state is ARMED or POST.
- done_o  out  1  state is DONE.

Function
REQ-005 SHALL implement FSM states IDLE, ARMED, POST, DONE.
REQ-006 conf_i SHALL be latched on conf_valid_i only in IDLE or DONE; ignored in ARMED/POST.
REQ-007 arm_i in IDLE/DONE SHALL: clear the write pointer to 0, set status to STATUS_DEFAULT, clear the event count, and enter ARMED next cycle; ignored in ARMED/POST.
REQ-008 In ARMED/POST each data_valid_i cycle SHALL produce we_o=1, wdata_o=data_i, waddr_o=pointer one cycle later (1-cycle registered latency); the pointer then increments, wrapping DEPTH-1 -> 0.
REQ-009 we_o SHALL be 0 in IDLE/DONE and on cycles without data_valid_i.
REQ-010 Trigger: in ARMED, data_valid_i with trigger_i != 0 SHALL set status.trg_event=1, event_pos = index of lowest set bit of trigger_i, and event_addr = address that word is written to; trigger_i is ignored when data_valid_i=0 and in POST.
REQ-011 Post-trigger count SHALL be P = trg_delay * DEPTH/4 words (0, 8, 16, 24 for DEPTH=32), not counting the trigger word.
REQ-012 If P=0: the trigger word is the last word of the event; otherwise ARMED -> POST, and POST ends after P further valid words.
REQ-013 At event end: trg_mode=0 -> DONE; trg_mode=1 -> ARMED while captured events < trg_num_traces+1, else DONE.
REQ-014 In mode 1 re-arm, status_o SHALL reflect the most recent event; the pointer SHALL continue without reset.
REQ-015 stop_i SHALL win over all other inputs: from any state, go to IDLE next cycle; any write accepted that cycle still completes; status_o is held.
REQ-016 status_o SHALL be registered and change only on trigger, arm_i or reset.

Reset
REQ-017 Reset SHALL give: state IDLE, pointer 0, we_o=0, waddr_o=0, wdata_o=0, status_o=STATUS_DEFAULT, busy_o=0, done_o=0, latched config=CONFIG_DEFAULT, event count 0.
REQ-018 Reset asserted mid-capture SHALL abort immediately; no write SHALL issue after rst_ni falls.

Configuration
REQ-019 Macro DTB_EVENT_COUNTER_EN: when defined, SHALL add output evt_cnt_o [7:0], a saturating count of accepted trigger events since the last arm_i, reset 0.
REQ-020 Without DTB_EVENT_COUNTER_EN, evt_cnt_o SHALL be absent; all other behaviour is identical.

Structure
REQ-021 config_t, status_t, CONFIG_DEFAULT, STATUS_DEFAULT and TRB_* constants SHALL come from DTB_PKG; an FSM state enum trb_wr_state_t SHALL be added to DTB_PKG.
REQ-022 Lowest-set-bit encoding SHALL be a sub-module trb_prio_enc (WIDTH in, $clog2(WIDTH) index + valid out, combinational).

Verification
REQ-023 Reset and default config, arm, 40 valid words, trigger_i=0x0000_0100 on word 5 -> event_pos=8, event_addr=5, 24 post words, DONE after word 29, last waddr_o=29.
REQ-024 trg_delay=0, trigger_i=0x8000_0001 on word 3 -> event_pos=0, event_addr=3, DONE the cycle after word 3 is written.
REQ-025 trg_mode=1, trg_num_traces=1, trg_delay=1: triggers on words 2 and 20 -> two events; status event_addr=20; DONE after word 28; word 6 trigger bits ignored (POST).
REQ-026 Wrap: delay=3, trigger on word 30 -> post writes to addresses 31, 0..22; DONE after address 22 written.
REQ-027 stop_i at cycle 10 of POST with data_valid_i=1 -> that write completes, IDLE next cycle, status_o held, busy_o=0.
REQ-028 rst_ni low during ARMED with data_valid_i=1 -> we_o=0 immediately, all outputs at reset values; with DTB_EVENT_COUNTER_EN, evt_cnt_o=0.
